// File: rtl/rbm_pkg.sv
// Shared constants and types for the RBM hidden-layer slave: address map,
// FSM states, counter sizing and the LFSR used by the RBM_SAMPLE_EN build.
package rbm_pkg;

    // Word address map
    localparam int unsigned ADDR_CTRL    = 0;
    localparam int unsigned ADDR_THRESH  = 1;
    localparam int unsigned ADDR_VISIBLE = 2;
    localparam int unsigned ADDR_HIDDEN  = 3;
    localparam int unsigned WEIGHT_BASE  = 4;

    // CTRL register bit positions
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    // Run sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rbm_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Width needed to hold a popcount of 0..dw (CNT_W)
    function automatic int unsigned cnt_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    // One LFSR step: shift left, feedback is the XOR of the tapped bits
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rbm_popcount.sv
// Registered population count of a DATA_WIDTH-bit vector (datapath stage S1).
module rbm_popcount
    import rbm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned CNT_W      = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [CNT_W-1:0]      o_count
);

    logic [CNT_W-1:0] w_sum;

    // Sum of set bits; CNT_W holds DATA_WIDTH without wrapping
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            w_sum = w_sum + CNT_W'(i_data[i]);
        end
    end

    // Output register closing stage S1
    always_ff @(posedge clk) begin
        if (reset) begin
            o_count <= '0;
        end else begin
            o_count <= w_sum;
        end
    end

endmodule

// File: rtl/rbm_hidden_layer.sv
// Avalon-MM slave evaluating one binary RBM hidden layer:
// hidden[h] = popcount(visible & weight[h]) >= threshold, for h = 0..NUM_HIDDEN-1.
// Optional macro RBM_SAMPLE_EN adds LFSR noise to the threshold per unit.
module rbm_hidden_layer
    import rbm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned NUM_HIDDEN = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NOISE_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] avs_s0_address,
    input  logic                  avs_s0_read,
    input  logic                  avs_s0_write,
    input  logic [DATA_WIDTH-1:0] avs_s0_writedata,
    output logic [DATA_WIDTH-1:0] avs_s0_readdata
);

    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
    localparam int unsigned CMP_W = CNT_W + 1;
    localparam int unsigned HW    = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1;

    rbm_state_e r_state;
    rbm_state_e w_state_nxt;
    logic       w_issue;
    logic       w_complete;

    logic [31:0]   w_addr32;
    logic          w_hit_ctrl;
    logic          w_hit_thresh;
    logic          w_hit_visible;
    logic          w_hit_hidden;
    logic          w_hit_wt;
    logic [HW-1:0] w_wt_idx;

    logic w_busy;
    logic w_start;
    logic w_clear;
    logic w_cfg_we;
    logic w_wt_we;
    logic w_host_ram_rd;
    logic w_ram_re;

    logic [CNT_W-1:0]      r_thresh;
    logic [DATA_WIDTH-1:0] r_visible;
    logic [NUM_HIDDEN-1:0] r_hidden;
    logic [NUM_HIDDEN-1:0] r_shadow;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_rd_ram;

    logic [DATA_WIDTH-1:0] r_mem [NUM_HIDDEN];
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic [HW-1:0]         w_ram_raddr;

    logic [HW-1:0]      r_issue_h;
    logic               r_s0_v;
    logic [HW-1:0]      r_s0_h;
    logic [NOISE_W-1:0] r_s0_noise;
    logic               r_s1_v;
    logic [HW-1:0]      r_s1_h;
    logic [NOISE_W-1:0] r_s1_noise;
    logic [NOISE_W-1:0] w_noise;

    logic [DATA_WIDTH-1:0] w_and;
    logic [CNT_W-1:0]      w_count;
    logic [CMP_W-1:0]      w_eff;
    logic                  w_fire;

    // Address decode
    assign w_addr32      = 32'(avs_s0_address);
    assign w_hit_ctrl    = (w_addr32 == ADDR_CTRL);
    assign w_hit_thresh  = (w_addr32 == ADDR_THRESH);
    assign w_hit_visible = (w_addr32 == ADDR_VISIBLE);
    assign w_hit_hidden  = (w_addr32 == ADDR_HIDDEN);
    assign w_hit_wt      = (w_addr32 >= WEIGHT_BASE) && (w_addr32 < WEIGHT_BASE + NUM_HIDDEN);
    assign w_wt_idx      = HW'(w_addr32 - WEIGHT_BASE);

    // Host command qualification; configuration is frozen while a run is active
    assign w_busy   = (r_state != IDLE);
    assign w_start  = avs_s0_write && w_hit_ctrl && avs_s0_writedata[CTRL_START_BIT] && !w_busy;
    assign w_clear  = avs_s0_write && w_hit_ctrl && avs_s0_writedata[CTRL_CLEAR_BIT];
    assign w_cfg_we = avs_s0_write && !w_busy;
    assign w_wt_we  = w_cfg_we && w_hit_wt;

    // The datapath owns the RAM read port while issuing; host weight reads get it otherwise
    assign w_host_ram_rd = avs_s0_read && w_hit_wt && (r_state != RUN);
    assign w_ram_re      = w_issue || w_host_ram_rd;
    assign w_ram_raddr   = w_issue ? r_issue_h : w_wt_idx;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state: issue one unit per RUN cycle, then wait for the pipe to empty
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (r_issue_h == HW'(NUM_HIDDEN - 1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_s0_v && !r_s1_v) begin
                    w_state_nxt = IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef RBM_SAMPLE_EN
    logic [15:0] r_lfsr;

    // Noise source, stepped once per issued unit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_issue) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_noise = r_lfsr[NOISE_W-1:0];
`else
    assign w_noise = '0;
`endif

    // Configuration registers, writable only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_thresh  <= '0;
            r_visible <= '0;
        end else if (w_cfg_we) begin
            if (w_hit_thresh) begin
                r_thresh <= avs_s0_writedata[CNT_W-1:0];
            end
            if (w_hit_visible) begin
                r_visible <= avs_s0_writedata;
            end
        end
    end

    // Weight store: simple dual port, read-before-write, contents survive reset
    always_ff @(posedge clk) begin
        if (w_wt_we) begin
            r_mem[w_wt_idx] <= avs_s0_writedata;
        end
        if (w_ram_re) begin
            r_ram_q <= r_mem[w_ram_raddr];
        end
    end

    // Issue counter and pipeline tags for stages S0 and S1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_h  <= '0;
            r_s0_v     <= 1'b0;
            r_s0_h     <= '0;
            r_s0_noise <= '0;
            r_s1_v     <= 1'b0;
            r_s1_h     <= '0;
            r_s1_noise <= '0;
        end else begin
            if (w_start) begin
                r_issue_h <= '0;
            end else if (w_issue) begin
                r_issue_h <= r_issue_h + HW'(1);
            end
            r_s0_v     <= w_issue;
            r_s0_h     <= r_issue_h;
            r_s0_noise <= w_noise;
            r_s1_v     <= r_s0_v;
            r_s1_h     <= r_s0_h;
            r_s1_noise <= r_s0_noise;
        end
    end

    assign w_and = r_visible & r_ram_q;

    rbm_popcount #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_popcount (
        .clk     (clk),
        .reset   (reset),
        .i_data  (w_and),
        .o_count (w_count)
    );

    // Stage S2 compare, one bit wider than the count so THRESH + noise cannot wrap
    assign w_eff  = CMP_W'(r_thresh) + CMP_W'(r_s1_noise);
    assign w_fire = (CMP_W'(w_count) >= w_eff);

    // Shadow result accumulation and atomic publish to HIDDEN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_hidden <= '0;
        end else begin
            if (w_start) begin
                r_shadow <= '0;
            end else if (r_s1_v) begin
                r_shadow[r_s1_h] <= w_fire;
            end
            if (w_complete) begin
                r_hidden <= r_shadow;
            end
        end
    end

    // Sticky done: completion sets it, start or clear drop it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_complete) begin
            r_done <= 1'b1;
        end else if (w_start || w_clear) begin
            r_done <= 1'b0;
        end
    end

    // Read mux with one-cycle latency; weight rows come straight from the RAM register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
            r_rd_ram   <= 1'b0;
        end else begin
            r_rd_ram <= w_host_ram_rd;
            if (avs_s0_read) begin
                if (w_hit_ctrl) begin
                    r_readdata <= DATA_WIDTH'({r_done, w_busy});
                end else if (w_hit_thresh) begin
                    r_readdata <= DATA_WIDTH'(r_thresh);
                end else if (w_hit_visible) begin
                    r_readdata <= r_visible;
                end else if (w_hit_hidden) begin
                    r_readdata <= DATA_WIDTH'(r_hidden);
                end else begin
                    r_readdata <= '0;
                end
            end
        end
    end

    assign avs_s0_readdata = r_rd_ram ? r_ram_q : r_readdata;

endmodule
